// File: rtl/code_patch_pkg.sv
// Shared definitions for the code-patch table loader.
//   state_t     : loader FSM states
//   header_t    : layout of the 32-bit load header word
//   MAGIC_DEFAULT / HDR_* : header tag value and field offsets
//   hdr_range_ok: checks that start+count fits inside the slot table
package code_patch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  localparam int HDR_TAG_LSB   = 24;
  localparam int HDR_EN_BIT    = 16;
  localparam int HDR_START_LSB = 8;
  localparam int HDR_COUNT_LSB = 0;

  typedef struct packed {
    logic [7:0] tag;       // [31:24]
    logic [6:0] rsvd;      // [23:17], ignored
    logic       en_after;  // [16]
    logic [7:0] start;     // [15:8]
    logic [7:0] count;     // [7:0]
  } header_t;

  // The sum is taken at 9 bits so start+count cannot wrap past 255.
  function automatic logic hdr_range_ok(input logic [7:0] start,
                                        input logic [7:0] count,
                                        input int unsigned num_slots);
    logic [8:0] sum;
    sum = {1'b0, start} + {1'b0, count};
    return (sum <= 9'(num_slots));
  endfunction

endpackage

// File: rtl/code_patch_loader.sv
// Writer side of the code-patch table. Consumes a valid/ready stream of
// 32-bit config words (header, then addr/data pairs) and issues one-cycle
// slot write strobes. Owns the core's global patch enable and holds it low
// while the table is being rewritten.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   s_valid_i/s_data_i      config word stream in
//   s_ready_o               word accepted this cycle when high with valid
//   abort_i                 cancel the load in progress
//   pt_we_o/pt_slot_o/
//   pt_addr_o/pt_data_o     slot write port to the patch table
//   cfg_pat_gen_o           global patch enable to the core
//   busy_o                  load in progress
//   done_o / err_o          one-cycle completion / header-reject pulses
module code_patch_loader
  import code_patch_pkg::*;
#(
  parameter int         NUM_SLOTS = 8,
  parameter int         ADDR_W    = 22,
  parameter int         DATA_W    = 32,
  parameter logic [7:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         s_valid_i,
  input  logic [31:0]                  s_data_i,
  output logic                         s_ready_o,
  input  logic                         abort_i,
  output logic                         pt_we_o,
  output logic [$clog2(NUM_SLOTS)-1:0] pt_slot_o,
  output logic [ADDR_W-1:0]            pt_addr_o,
  output logic [DATA_W-1:0]            pt_data_o,
  output logic                         cfg_pat_gen_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  state_t              state_reg;
  logic [SLOT_W-1:0]   slot_reg;
  logic [7:0]          remain_reg;
  logic                en_reg;
  logic [ADDR_W-1:0]   addr_reg;

  logic                pt_we_reg;
  logic [SLOT_W-1:0]   pt_slot_reg;
  logic [ADDR_W-1:0]   pt_addr_reg;
  logic [DATA_W-1:0]   pt_data_reg;
  logic                cfg_reg;

  header_t             hdr;
  logic                hdr_ok;
  logic [6:0]          unused_rsvd;

  assign hdr         = header_t'(s_data_i);
  assign hdr_ok      = (hdr.tag == MAGIC) && hdr_range_ok(hdr.start, hdr.count, NUM_SLOTS);
  assign unused_rsvd = hdr.rsvd;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      slot_reg    <= '0;
      remain_reg  <= '0;
      en_reg      <= 1'b0;
      addr_reg    <= '0;
      pt_we_reg   <= 1'b0;
      pt_slot_reg <= '0;
      pt_addr_reg <= '0;
      pt_data_reg <= '0;
      cfg_reg     <= 1'b0;
    end else begin
      pt_we_reg <= 1'b0;
      if (state_reg != IDLE && abort_i) begin
        // A strobe already presented in WR completes this cycle; nothing
        // further is written and the table stays disabled.
        state_reg <= IDLE;
        cfg_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (s_valid_i) begin
              if (!hdr_ok) begin
                state_reg <= ERR;
              end else if (hdr.count == 8'd0) begin
                en_reg    <= hdr.en_after;
                state_reg <= DONE;
              end else begin
                slot_reg   <= hdr.start[SLOT_W-1:0];
                remain_reg <= hdr.count;
                en_reg     <= hdr.en_after;
                cfg_reg    <= 1'b0;  // never expose a half-written table
                state_reg  <= ADDR;
              end
            end
          end
          ADDR: begin
            if (s_valid_i) begin
              addr_reg  <= s_data_i[ADDR_W-1:0];
              state_reg <= DATA;
            end
          end
          DATA: begin
            if (s_valid_i) begin
              // Load the write port directly so the strobe lands in WR.
              pt_we_reg   <= 1'b1;
              pt_slot_reg <= slot_reg;
              pt_addr_reg <= addr_reg;
              pt_data_reg <= s_data_i[DATA_W-1:0];
              state_reg   <= WR;
            end
          end
          WR: begin
            slot_reg   <= slot_reg + SLOT_W'(1);
            remain_reg <= remain_reg - 8'd1;
            state_reg  <= (remain_reg == 8'd1) ? DONE : ADDR;
          end
          DONE: begin
            cfg_reg   <= en_reg;
            state_reg <= IDLE;
          end
          ERR: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign s_ready_o     = (state_reg == IDLE) || (state_reg == ADDR) || (state_reg == DATA);
  assign busy_o        = (state_reg != IDLE);
  // An abort landing on DONE/ERR suppresses the pulse.
  assign done_o        = (state_reg == DONE) && !abort_i;
  assign err_o         = (state_reg == ERR) && !abort_i;
  assign pt_we_o       = pt_we_reg;
  assign pt_slot_o     = pt_slot_reg;
  assign pt_addr_o     = pt_addr_reg;
  assign pt_data_o     = pt_data_reg;
  assign cfg_pat_gen_o = cfg_reg;

endmodule

// File: tb/tb_code_patch_loader.sv
module tb_code_patch_loader;

  localparam int NS = 8;
  localparam int AW = 22;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          s_valid_i;
  logic [31:0]   s_data_i;
  logic          s_ready_o;
  logic          abort_i;
  logic          pt_we_o;
  logic [2:0]    pt_slot_o;
  logic [AW-1:0] pt_addr_o;
  logic [DW-1:0] pt_data_o;
  logic          cfg_pat_gen_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  code_patch_loader #(
    .NUM_SLOTS(NS), .ADDR_W(AW), .DATA_W(DW), .MAGIC(8'hA5)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .abort_i(abort_i),
    .pt_we_o(pt_we_o), .pt_slot_o(pt_slot_o), .pt_addr_o(pt_addr_o), .pt_data_o(pt_data_o),
    .cfg_pat_gen_o(cfg_pat_gen_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    int            slot;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         wr_q[$];
  int          ev_q[$];   // 1 = done pulse, 2 = err pulse
  wr_t         mon_e;
  int          mon_ev;
  bit          model_cfg;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] a_arr[8];
  logic [31:0] d_arr[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every DUT write/done/err is matched against the queue.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (pt_we_o) begin
        check("ready_low_in_wr", 64'(s_ready_o), 64'd0);
        if (wr_q.size() == 0) begin
          check("unexpected_write", 64'(pt_slot_o), 64'hFFFF);
        end else begin
          mon_e = wr_q.pop_front();
          check("wr_slot", 64'(pt_slot_o), 64'(mon_e.slot));
          check("wr_addr", 64'(pt_addr_o), 64'(mon_e.addr));
          check("wr_data", 64'(pt_data_o), 64'(mon_e.data));
        end
        $display("write slot=%0d addr=%0h data=%0h", pt_slot_o, pt_addr_o, pt_data_o);
      end
      if (done_o || err_o) begin
        mon_ev = (ev_q.size() == 0) ? 0 : ev_q.pop_front();
        check("event_kind", {62'd0, err_o, done_o}, 64'(mon_ev));
        $display("event %s", done_o ? "done" : "err");
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [31:0] w, input bit gaps);
    bit acc;
    int n;
    n = gaps ? int'($urandom_range(0, 3)) : 0;
    s_valid_i = 1'b0;
    repeat (n) begin
      s_data_i = $urandom;
      @(posedge clk_i); #1;
    end
    s_valid_i = 1'b1;
    s_data_i  = w;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) begin
      acc = s_ready_o;  // state only changes on edges, so this holds at the next edge
      @(posedge clk_i); #1;
    end
    s_valid_i = 1'b0;
    s_data_i  = $urandom;
    if (!acc) check("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 100 && !idle; t++) begin
      if (!busy_o) idle = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    if (!idle) check("idle_timeout", 64'd0, 64'd1);
    @(negedge clk_i);
    check("cfg_after_load", 64'(cfg_pat_gen_o), 64'(model_cfg));
    check("sb_drained", 64'(wr_q.size() + ev_q.size()), 64'd0);
    @(posedge clk_i); #1;
  endtask

  // Reference: a good header writes slots start..start+count-1 from the
  // addr/data pairs in order, then reports done and adopts en_after;
  // a bad tag or an out-of-range span reports err and changes nothing.
  task automatic do_load(input logic [31:0] hdr, input bit gaps);
    logic [7:0] tag, start, cnt;
    bit en, bad;
    tag   = hdr[31:24];
    en    = hdr[16];
    start = hdr[15:8];
    cnt   = hdr[7:0];
    bad   = (tag != 8'hA5) || (int'(start) + int'(cnt) > NS);
    $display("load hdr=%08h bad=%0d start=%0d count=%0d en=%0d", hdr, bad, start, cnt, en);
    if (bad) begin
      ev_q.push_back(2);
    end else begin
      for (int i = 0; i < int'(cnt); i++)
        wr_q.push_back('{int'(start) + i, a_arr[i][AW-1:0], d_arr[i][DW-1:0]});
      ev_q.push_back(1);
      model_cfg = en;
    end
    send_word(hdr, gaps);
    if (bad) begin
      check("err_after_header", 64'(err_o), 64'd1);
    end else if (cnt == 8'd0) begin
      check("done_after_header", 64'(done_o), 64'd1);
    end else begin
      check("cfg_cleared_in_load", 64'(cfg_pat_gen_o), 64'd0);
      for (int i = 0; i < int'(cnt); i++) begin
        send_word(a_arr[i], gaps);
        send_word(d_arr[i], gaps);
        check("write_latency", 64'(pt_we_o), 64'd1);
      end
    end
    wait_idle();
  endtask

  initial begin
    logic [7:0] st, ct, tg;
    rst_i = 1'b1; s_valid_i = 1'b0; s_data_i = '0; abort_i = 1'b0;
    model_cfg = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cfg",  64'(cfg_pat_gen_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_we",   64'(pt_we_o), 64'd0);
    check("rst_done_err", {62'd0, done_o, err_o}, 64'd0);
    check("rst_addr", 64'(pt_addr_o), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("idle_ready", 64'(s_ready_o), 64'd1);

    // Directed loads
    a_arr[0] = 32'h0000_0100; d_arr[0] = 32'hDEAD_0001;
    a_arr[1] = 32'h0000_0200; d_arr[1] = 32'hDEAD_0002;
    do_load(32'hA501_0002, 1'b0);
    do_load(32'h5A01_0001, 1'b0);
    do_load(32'hA501_0703, 1'b0);
    do_load(32'hA500_0000, 1'b0);

    // Abort during the second DATA phase of a 3-slot load
    do_load(32'hA501_0001, 1'b0);  // leave the enable on beforehand
    for (int i = 0; i < 3; i++) begin a_arr[i] = $urandom; d_arr[i] = $urandom; end
    $display("load hdr=A5010003 abort in second DATA");
    wr_q.push_back('{0, a_arr[0][AW-1:0], d_arr[0]});
    model_cfg = 1'b0;
    send_word(32'hA501_0003, 1'b0);
    send_word(a_arr[0], 1'b0);
    send_word(d_arr[0], 1'b0);
    check("write_latency", 64'(pt_we_o), 64'd1);
    send_word(a_arr[1], 1'b0);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    check("busy_after_abort", 64'(busy_o), 64'd0);
    check("cfg_after_abort", 64'(cfg_pat_gen_o), 64'd0);
    repeat (4) @(posedge clk_i);
    #1;
    wait_idle();

    // 4-slot load with random valid gaps
    for (int i = 0; i < 8; i++) begin a_arr[i] = $urandom; d_arr[i] = $urandom; end
    st = 8'($urandom_range(0, 4));
    do_load({8'hA5, 7'd0, 1'b1, st, 8'd4}, 1'b1);

    // Random headers, including bad tags, overflowing spans and empty loads
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 8; i++) begin a_arr[i] = $urandom; d_arr[i] = $urandom; end
      tg = ($urandom_range(0, 7) == 0) ? 8'h3C : 8'hA5;
      st = 8'($urandom_range(0, 8));
      ct = 8'($urandom_range(0, 5));
      do_load({tg, 7'($urandom), 1'($urandom), st, ct}, 1'($urandom));
    end

    // Reset in the middle of a load
    a_arr[0] = 32'h0000_0ABC; d_arr[0] = 32'h1234_5678;
    do_load(32'hA501_0001, 1'b0);
    $display("load hdr=A5010002 reset in DATA");
    send_word(32'hA501_0002, 1'b0);
    send_word(32'h0000_0333, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_cfg = 1'b0;
    check("busy_after_reset", 64'(busy_o), 64'd0);
    check("cfg_after_reset", 64'(cfg_pat_gen_o), 64'd0);
    check("we_after_reset", 64'(pt_we_o), 64'd0);
    repeat (4) @(posedge clk_i);
    #1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
